// File: rtl/filter_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : filter_line_scheduler
//  Description : Frame/line sequencer for the three-channel 3x3 filter
//                datapath. Tracks the raster position of incoming pixels,
//                rotates the three line buffers round-robin, flags cycles
//                with a complete 3x3 window, re-times that flag through the
//                filter pipeline latency and reports frame completion.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_enable          - global clock enable (low freezes all)
//                i_start           - frame start request (IDLE only)
//                i_pix_valid       - source pixel strobe
//                o_busy            - FILL, RUN or FLUSH in progress
//                o_wr_line_sel     - line buffer being written (0..2)
//                o_sel_line1/2     - line buffers one/two rows above
//                o_col, o_row      - position of the next pixel to accept
//                o_window_valid    - full 3x3 window present
//                o_data_valid_out  - filtered pixel valid at filter outputs
//                o_frame_done      - one-cycle end-of-frame pulse
//                o_frames          - completed frame count (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_line_scheduler #(
  parameter int WIDTH_IMG = 255,
  parameter int HIGH_IMG  = 255,
  parameter int PIPE_LAT  = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_pix_valid,
  output logic             o_busy,
  output logic [1:0]       o_wr_line_sel,
  output logic [1:0]       o_sel_line1,
  output logic [1:0]       o_sel_line2,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_window_valid,
  output logic             o_data_valid_out,
  output logic             o_frame_done,
  output logic [31:0]      o_frames
);

  localparam int                c_FCNT_W      = $clog2(PIPE_LAT + 1);
  localparam logic [c_FCNT_W-1:0] c_FLUSH_LAST = c_FCNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0]  c_COL_LAST    = CNT_W'(WIDTH_IMG - 1);
  localparam logic [CNT_W-1:0]  c_ROW_LAST    = CNT_W'(HIGH_IMG - 1);
  localparam logic [CNT_W-1:0]  c_ROW_FILL_END = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_WIN_MIN     = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_col;
  logic [CNT_W-1:0]      r_row;
  logic [1:0]            r_wr_line_sel;
  logic [1:0]            w_wr_next;
  logic [c_FCNT_W-1:0]   r_flush_cnt;
  logic                  r_window_valid;
  logic                  r_frame_done;
  logic [31:0]           r_frames;
  logic [PIPE_LAT-1:0]   r_dly;

  logic                  w_col_last;
  logic                  w_accept;
  logic                  w_frame_start;
  logic                  w_last_pix;
  logic                  w_flush_end;

  assign w_col_last = (r_col == c_COL_LAST);
  assign w_wr_next  = (r_wr_line_sel == 2'd2) ? 2'd0 : r_wr_line_sel + 2'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (i_enable) begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and per-cycle control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_accept      = 1'b0;
    w_last_pix    = 1'b0;
    w_flush_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The frame_done cycle is still IDLE; a start seen there is dropped
        // so a new frame cannot overlap the completion pulse.
        if (i_start && !r_frame_done) begin
          w_frame_start = 1'b1;
          w_state_nxt   = ST_FILL;
        end
      end
      ST_FILL: begin
        w_accept = i_pix_valid;
        if (i_pix_valid && w_col_last && (r_row == c_ROW_FILL_END)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_accept = i_pix_valid;
        if (i_pix_valid && w_col_last && (r_row == c_ROW_LAST)) begin
          w_last_pix  = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == c_FLUSH_LAST) begin
          w_flush_end = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Raster position, line rotation, window flag, frame bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col          <= '0;
      r_row          <= '0;
      r_wr_line_sel  <= 2'd0;
      r_flush_cnt    <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frames       <= 32'd0;
    end else if (i_enable) begin
      // Rows 0/1 never satisfy row>=2, so FILL cannot raise the flag.
      r_window_valid <= w_accept && (r_row >= c_WIN_MIN) && (r_col >= c_WIN_MIN);
      r_frame_done   <= w_flush_end;

      if (w_frame_start) begin
        r_col         <= '0;
        r_row         <= '0;
        r_wr_line_sel <= 2'd0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col         <= '0;
          r_wr_line_sel <= w_wr_next;
          // Last pixel of the frame parks the row at 0 for the idle period.
          r_row         <= w_last_pix ? '0 : r_row + CNT_W'(1);
        end else begin
          r_col <= r_col + CNT_W'(1);
        end
      end

      // Counts enabled FLUSH cycles; sits at 0 everywhere else.
      if ((r_state == ST_FLUSH) && !w_flush_end) begin
        r_flush_cnt <= r_flush_cnt + c_FCNT_W'(1);
      end else begin
        r_flush_cnt <= '0;
      end

      if (w_flush_end) begin
        r_frames <= r_frames + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // window_valid re-timed through the filter pipeline latency
  // --------------------------------------------------------------------------
  generate
    if (PIPE_LAT == 1) begin : g_dly_single
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly <= '0;
        end else if (i_enable) begin
          r_dly <= r_window_valid;
        end
      end
    end else begin : g_dly_multi
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly <= '0;
        end else if (i_enable) begin
          r_dly <= {r_dly[PIPE_LAT-2:0], r_window_valid};
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read selects: the buffer written two rows ago and one row ago.
  // --------------------------------------------------------------------------
  always_comb begin
    o_sel_line1 = 2'd2;
    o_sel_line2 = 2'd1;
    case (r_wr_line_sel)
      2'd1: begin
        o_sel_line1 = 2'd0;
        o_sel_line2 = 2'd2;
      end
      2'd2: begin
        o_sel_line1 = 2'd1;
        o_sel_line2 = 2'd0;
      end
      default: ;
    endcase
  end

  assign o_busy           = (r_state != ST_IDLE);
  assign o_wr_line_sel    = r_wr_line_sel;
  assign o_col            = r_col;
  assign o_row            = r_row;
  assign o_window_valid   = r_window_valid;
  assign o_data_valid_out = r_dly[PIPE_LAT-1];
  assign o_frame_done     = r_frame_done;
  assign o_frames         = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_filter_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_line_scheduler
//  Description : Self-checking bench for filter_line_scheduler. DUT A runs
//                4x4 frames with latency 3; DUT B runs 5x3 frames with
//                latency 1. Window, data-valid and frame-done pulses are
//                predicted into queues when pixels are driven and compared
//                every cycle; raster state is checked from a vector table
//                and from hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_line_scheduler;

  localparam int c_CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic a_en = 1'b1, a_start = 1'b0, a_pv = 1'b0;
  logic b_en = 1'b1, b_start = 1'b0, b_pv = 1'b0;

  logic            a_busy, a_wv, a_dv, a_done, b_busy, b_wv, b_dv, b_done;
  logic [1:0]      a_wr, a_s1, a_s2, b_wr, b_s1, b_s2;
  logic [c_CW-1:0] a_col, a_row, b_col, b_row;
  logic [31:0]     a_frames, b_frames;

  filter_line_scheduler #(.WIDTH_IMG(4), .HIGH_IMG(4), .PIPE_LAT(3), .CNT_W(c_CW)) u_dut_a (
    .clk(clk), .rst(rst), .i_enable(a_en), .i_start(a_start), .i_pix_valid(a_pv),
    .o_busy(a_busy), .o_wr_line_sel(a_wr), .o_sel_line1(a_s1), .o_sel_line2(a_s2),
    .o_col(a_col), .o_row(a_row), .o_window_valid(a_wv), .o_data_valid_out(a_dv),
    .o_frame_done(a_done), .o_frames(a_frames));

  filter_line_scheduler #(.WIDTH_IMG(5), .HIGH_IMG(3), .PIPE_LAT(1), .CNT_W(c_CW)) u_dut_b (
    .clk(clk), .rst(rst), .i_enable(b_en), .i_start(b_start), .i_pix_valid(b_pv),
    .o_busy(b_busy), .o_wr_line_sel(b_wr), .o_sel_line1(b_s1), .o_sel_line2(b_s2),
    .o_col(b_col), .o_row(b_row), .o_window_valid(b_wv), .o_data_valid_out(b_dv),
    .o_frame_done(b_done), .o_frames(b_frames));

  int n_vec = 0;
  int n_bad = 0;
  int a_ec = 0, b_ec = 0;          // enabled clock edges seen by each DUT
  int a_wcnt = 0, b_wcnt = 0;      // window pulses (counted on enabled edges)
  int a_dcnt = 0, b_dcnt = 0;      // frame_done pulses
  int a_winq[$], a_dvq[$], a_doneq[$];
  int b_winq[$], b_dvq[$], b_doneq[$];

  typedef struct {
    bit st; bit pv; int pr; int pc; bit last;
    int busy; int col; int row; int wr; int frames;
  } vec_t;
  vec_t vt[23];
  int   s1_lut[3] = '{2, 0, 1};
  int   s2_lut[3] = '{1, 2, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: advance, then compare pulse outputs against the scoreboards.
  task automatic tick();
    bit ea, eb;
    ea = a_en;
    eb = b_en;
    @(posedge clk);
    #1;
    if (ea) a_ec++;
    if (eb) b_ec++;
    while (a_winq.size() > 0 && a_winq[0] < a_ec) void'(a_winq.pop_front());
    while (a_dvq.size() > 0 && a_dvq[0] < a_ec) void'(a_dvq.pop_front());
    while (a_doneq.size() > 0 && a_doneq[0] < a_ec) void'(a_doneq.pop_front());
    while (b_winq.size() > 0 && b_winq[0] < b_ec) void'(b_winq.pop_front());
    while (b_dvq.size() > 0 && b_dvq[0] < b_ec) void'(b_dvq.pop_front());
    while (b_doneq.size() > 0 && b_doneq[0] < b_ec) void'(b_doneq.pop_front());
    chk("A window_valid", a_wv, (a_winq.size() > 0) ? 32'(a_winq[0] == a_ec) : 32'd0);
    chk("A data_valid_out", a_dv, (a_dvq.size() > 0) ? 32'(a_dvq[0] == a_ec) : 32'd0);
    chk("A frame_done", a_done, (a_doneq.size() > 0) ? 32'(a_doneq[0] == a_ec) : 32'd0);
    chk("B window_valid", b_wv, (b_winq.size() > 0) ? 32'(b_winq[0] == b_ec) : 32'd0);
    chk("B data_valid_out", b_dv, (b_dvq.size() > 0) ? 32'(b_dvq[0] == b_ec) : 32'd0);
    chk("B frame_done", b_done, (b_doneq.size() > 0) ? 32'(b_doneq[0] == b_ec) : 32'd0);
    if (ea && a_wv) a_wcnt++;
    if (eb && b_wv) b_wcnt++;
    if (ea && a_done) a_dcnt++;
    if (eb && b_done) b_dcnt++;
  endtask

  task automatic drive(input int id, input bit st, input bit pv, input bit en);
    if (id == 0) begin
      a_start = st; a_pv = pv; a_en = en;
    end else begin
      b_start = st; b_pv = pv; b_en = en;
    end
  endtask

  // Predict the pulses caused by a pixel accepted on the next enabled edge.
  task automatic push_pix(input int id, input int r, input int c, input bit last);
    if (id == 0) begin
      if (r >= 2 && c >= 2) begin
        a_winq.push_back(a_ec + 1);
        a_dvq.push_back(a_ec + 1 + 3);
      end
      if (last) a_doneq.push_back(a_ec + 2 + 3);
    end else begin
      if (r >= 2 && c >= 2) begin
        b_winq.push_back(b_ec + 1);
        b_dvq.push_back(b_ec + 1 + 1);
      end
      if (last) b_doneq.push_back(b_ec + 2 + 1);
    end
  endtask

  task automatic stall_a(input int n);
    logic [c_CW-1:0] sc, sr;
    logic [1:0]      sw;
    logic            sb;
    sc = a_col; sr = a_row; sw = a_wr; sb = a_busy;
    a_en = 1'b0;
    repeat (n) begin
      tick();
      chk("A stall col", a_col, sc);
      chk("A stall row", a_row, sr);
      chk("A stall wr_line_sel", a_wr, sw);
      chk("A stall busy", a_busy, sb);
    end
    a_en = 1'b1;
  endtask

  // Start + full frame; n = ticks from the start tick to the frame_done tick.
  task automatic run_frame(input int id, input bit stall, output int n);
    int w, h;
    bit d;
    w = (id == 0) ? 4 : 5;
    h = (id == 0) ? 4 : 3;
    n = 0;
    if (id == 0) a_wcnt = 0; else b_wcnt = 0;
    drive(id, 1'b1, 1'b1, 1'b1);   // pix_valid in the start cycle is dropped
    tick(); n++;
    for (int p = 0; p < w * h; p++) begin
      if (stall && p == 10) begin
        stall_a(3); n += 3;
      end
      drive(id, 1'b0, 1'b1, 1'b1);
      push_pix(id, p / w, p % w, p == w * h - 1);
      tick(); n++;
    end
    drive(id, 1'b0, 1'b1, 1'b1);   // pix_valid during FLUSH is ignored
    if (stall) begin
      tick(); n++;
      stall_a(3); n += 3;
    end
    d = (id == 0) ? a_done : b_done;
    while (!d && n < 60) begin
      tick(); n++;
      d = (id == 0) ? a_done : b_done;
    end
    drive(id, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    int n;

    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (2) tick();
    chk("A reset busy", a_busy, 0);
    chk("A reset col", a_col, 0);
    chk("A reset row", a_row, 0);
    chk("A reset wr_line_sel", a_wr, 0);
    chk("A reset frames", a_frames, 0);
    chk("B reset busy", b_busy, 0);
    rst = 1'b0;

    // ---------------- table-driven first frame ----------------
    vt[0] = '{st:1, pv:1, pr:-1, pc:-1, last:0, busy:1, col:0, row:0, wr:0, frames:0};
    for (int p = 0; p < 16; p++) begin
      vt[p+1] = '{st:0, pv:1, pr:p/4, pc:p%4, last:(p == 15), busy:1,
                  col:(p == 15) ? 0 : (p+1)%4, row:(p == 15) ? -1 : (p+1)/4,
                  wr:((p+1)/4)%3, frames:0};
    end
    vt[9].st = 1'b1;               // start during RUN is ignored
    for (int k = 17; k < 20; k++)
      vt[k] = '{st:0, pv:1, pr:-1, pc:-1, last:0, busy:1, col:0, row:-1, wr:1, frames:0};
    vt[20] = '{st:0, pv:1, pr:-1, pc:-1, last:0, busy:0, col:0, row:0, wr:1, frames:1};
    vt[21] = '{st:1, pv:0, pr:-1, pc:-1, last:0, busy:0, col:0, row:0, wr:1, frames:1};
    vt[22] = '{st:0, pv:0, pr:-1, pc:-1, last:0, busy:0, col:0, row:0, wr:1, frames:1};

    a_wcnt = 0;
    for (int k = 0; k < 23; k++) begin
      drive(0, vt[k].st, vt[k].pv, 1'b1);
      if (vt[k].pr >= 0) push_pix(0, vt[k].pr, vt[k].pc, vt[k].last);
      tick();
      chk($sformatf("A v%0d busy", k), a_busy, vt[k].busy);
      chk($sformatf("A v%0d col", k), a_col, vt[k].col);
      if (vt[k].row >= 0) chk($sformatf("A v%0d row", k), a_row, vt[k].row);
      chk($sformatf("A v%0d wr_line_sel", k), a_wr, vt[k].wr);
      chk($sformatf("A v%0d sel_line1", k), a_s1, s1_lut[vt[k].wr]);
      chk($sformatf("A v%0d sel_line2", k), a_s2, s2_lut[vt[k].wr]);
      chk($sformatf("A v%0d frames", k), a_frames, vt[k].frames);
    end
    chk("A frame1 windows", a_wcnt, 4);

    // ---------------- stalls in RUN and FLUSH ----------------
    run_frame(0, 1'b1, n);
    chk("A stalled frame_done latency", n, 27);
    chk("A stalled windows", a_wcnt, 4);
    chk("A stalled frames", a_frames, 2);

    // ---------------- mid-frame reset ----------------
    drive(0, 1'b1, 1'b0, 1'b1);
    tick();
    for (int p = 0; p < 9; p++) begin
      drive(0, 1'b0, 1'b1, 1'b1);
      push_pix(0, p / 4, p % 4, 1'b0);
      tick();
    end
    chk("A pre-reset col", a_col, 1);
    chk("A pre-reset row", a_row, 2);
    a_winq.delete(); a_dvq.delete(); a_doneq.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("A mid-reset busy", a_busy, 0);
    chk("A mid-reset col", a_col, 0);
    chk("A mid-reset frames", a_frames, 0);
    run_frame(0, 1'b0, n);
    chk("A post-reset frame_done latency", n, 21);
    chk("A post-reset windows", a_wcnt, 4);
    chk("A post-reset frames", a_frames, 1);

    // ---------------- back-to-back frames on 5x3, latency 1 ----------------
    b_dcnt = 0;
    run_frame(1, 1'b0, n);
    chk("B frame1 latency", n, 18);
    chk("B frame1 windows", b_wcnt, 3);
    chk("B frame1 frames", b_frames, 1);
    run_frame(1, 1'b0, n);
    chk("B frame2 latency", n, 18);
    chk("B frame2 windows", b_wcnt, 3);
    chk("B frame2 frames", b_frames, 2);
    repeat (3) tick();
    chk("B frame_done pulses", b_dcnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
